// File: rtl/histogram_chunker_pkg.sv
// Shared types and sizes for the histogram chunker and its per-bin subtract stage.
// HIST_DROP_CNT_EN (in the top) adds a dropped-pixel counter port.
package hist_pkg;
   localparam int NUM_BINS   = 256;
   localparam int CHUNK_BINS = 8;
   localparam int COUNT_W    = 16;
   localparam int BIN_W      = 17;
   localparam int NUM_CHUNKS = 32;

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} hist_state_t;
   typedef logic [15:0]        count_t;
   typedef logic signed [16:0] sbin_t;

   function automatic count_t sat_inc(input count_t c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction
endpackage

// File: rtl/histogram_chunker_sub.sv
// Per-bin floor subtract: eight unsigned counts minus one unsigned floor, packed as
// eight 17-bit signed bins (bin j at [(j+1)*17-1 : j*17]).
module hist_chunk_sub
   import hist_pkg::*;
(
   input  logic [CHUNK_BINS*COUNT_W-1:0] i_counts,
   input  count_t                        i_floor,
   output logic [CHUNK_BINS*BIN_W-1:0]   o_chunk
);

   sbin_t w_bin;

   // One extra bit on each operand keeps the full -65535..65535 range exact.
   always_comb begin
      o_chunk = '0;
      w_bin   = '0;
      for (int j = 0; j < CHUNK_BINS; j++) begin
         w_bin = $signed({1'b0, i_counts[j*COUNT_W +: COUNT_W]}) - $signed({1'b0, i_floor});
         o_chunk[j*BIN_W +: BIN_W] = w_bin;
      end
   end

endmodule

// File: rtl/histogram_chunker.sv
// Frame histogram (256 saturating bins) drained as 32 floor-subtracted chunks of 8 bins.
// Optional HIST_DROP_CNT_EN adds o_drop_count for pixels seen outside ACCUM.
module histogram_chunker
   import hist_pkg::*;
(
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_frame_start,
   input  logic                         i_frame_end,
   input  logic                         i_pixel_valid,
   input  logic [7:0]                   i_pixel,
   input  logic [15:0]                  i_floor,
   output logic                         o_chunk_valid,
   input  logic                         i_chunk_ready,
   output logic [CHUNK_BINS*BIN_W-1:0]  o_histogram_chunk,
   output logic [7:0]                   o_bin_index,
   output logic                         o_chunk_last,
   output logic                         o_busy
`ifdef HIST_DROP_CNT_EN
   ,
   output logic [15:0]                  o_drop_count
`endif
);

   hist_state_t r_state;
   hist_state_t w_next_state;
   logic [4:0]  r_k;
   count_t      r_floor;
   count_t      r_count [NUM_BINS];

   logic                          w_drain;
   logic                          w_accept;
   logic                          w_last_k;
   logic [CHUNK_BINS*COUNT_W-1:0] w_chunk_counts;
   logic [CHUNK_BINS*BIN_W-1:0]   w_chunk;

   // Chunk handshake: a chunk transfers on any cycle with o_chunk_valid && i_chunk_ready;
   // while valid is high and ready is low, every chunk output holds its value.
   assign w_drain  = (r_state == DRAIN);
   assign w_accept = w_drain && i_chunk_ready;
   assign w_last_k = (r_k == 5'(NUM_CHUNKS - 1));

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (i_frame_start) w_next_state = ACCUM;
         ACCUM:   if (i_frame_end) w_next_state = DRAIN;
         DRAIN:   if (w_accept && w_last_k) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_k     <= '0;
         r_floor <= '0;
      end else begin
         r_state <= w_next_state;
         if (r_state == ACCUM && i_frame_end) r_floor <= i_floor;
         if (w_accept) r_k <= r_k + 5'd1;
      end
   end

   // Accumulation and clear-on-consume never coincide: they live in different states.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NUM_BINS; i++) r_count[i] <= '0;
      end else if (r_state == ACCUM && i_pixel_valid) begin
         r_count[i_pixel] <= sat_inc(r_count[i_pixel]);
      end else if (w_accept) begin
         for (int j = 0; j < CHUNK_BINS; j++) r_count[{r_k, 3'(j)}] <= '0;
      end
   end

   always_comb begin
      w_chunk_counts = '0;
      for (int j = 0; j < CHUNK_BINS; j++)
         w_chunk_counts[j*COUNT_W +: COUNT_W] = r_count[{r_k, 3'(j)}];
   end

   hist_chunk_sub u_chunk_sub (
      .i_counts (w_chunk_counts),
      .i_floor  (r_floor),
      .o_chunk  (w_chunk)
   );

   assign o_chunk_valid     = w_drain;
   assign o_chunk_last      = w_drain && w_last_k;
   assign o_bin_index       = w_drain ? {r_k, 3'b000} : 8'd0;
   assign o_histogram_chunk = w_drain ? w_chunk : '0;
   assign o_busy            = (r_state != IDLE);

`ifdef HIST_DROP_CNT_EN
   count_t r_drop;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_drop <= '0;
      end else if (r_state == IDLE && i_frame_start) begin
         r_drop <= '0;
      end else if (r_state != ACCUM && i_pixel_valid) begin
         r_drop <= sat_inc(r_drop);
      end
   end

   assign o_drop_count = r_drop;
`endif

endmodule

// File: tb/tb_histogram_chunker.sv
// Directed bench for histogram_chunker: reference histogram array, floor subtract and
// chunk sequencing are computed here and compared against the chunk stream.
module tb_histogram_chunker;

   logic         clk;
   logic         rst_n;
   logic         frame_start;
   logic         frame_end;
   logic         pixel_valid;
   logic [7:0]   pixel;
   logic [15:0]  floor_in;
   logic         chunk_valid;
   logic         chunk_ready;
   logic [135:0] chunk;
   logic [7:0]   bin_index;
   logic         chunk_last;
   logic         busy;
`ifdef HIST_DROP_CNT_EN
   logic [15:0]  drop_count;
`endif

   int checks;
   int errors;
   int exp_hist [256];

   histogram_chunker dut (
      .i_clk             (clk),
      .i_rst_n           (rst_n),
      .i_frame_start     (frame_start),
      .i_frame_end       (frame_end),
      .i_pixel_valid     (pixel_valid),
      .i_pixel           (pixel),
      .i_floor           (floor_in),
      .o_chunk_valid     (chunk_valid),
      .i_chunk_ready     (chunk_ready),
      .o_histogram_chunk (chunk),
      .o_bin_index       (bin_index),
      .o_chunk_last      (chunk_last),
      .o_busy            (busy)
`ifdef HIST_DROP_CNT_EN
      ,
      .o_drop_count      (drop_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      for (int i = 0; i < 256; i++) exp_hist[i] = 0;
   endtask

   task automatic model_add(input int v);
      if (exp_hist[v] < 65535) exp_hist[v] = exp_hist[v] + 1;
   endtask

   task automatic start_frame();
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      chk("accum_busy", int'(busy), 1);
      chk("accum_no_valid", int'(chunk_valid), 0);
   endtask

   task automatic send_pix(input int v, input int n);
      pixel_valid = 1'b1;
      pixel       = 8'(v);
      for (int i = 0; i < n; i++) begin
         model_add(v);
         step();
      end
      pixel_valid = 1'b0;
   endtask

   task automatic end_frame(input bit with_pix, input int v, input int fl);
      frame_end   = 1'b1;
      pixel_valid = with_pix;
      pixel       = 8'(v);
      floor_in    = 16'(fl);
      if (with_pix) model_add(v);
      step();
      frame_end   = 1'b0;
      pixel_valid = 1'b0;
      floor_in    = 16'hABCD;
   endtask

   // Walks all chunks; optional stall at stall_k, drop pixels on first drop_n chunks,
   // and an asynchronous reset when abort_k is reached.
   task automatic drain(input int fl, input int stall_k, input int stall_n,
                        input int drop_n, input int abort_k);
      logic [135:0] cap;
      int gv;
      for (int k = 0; k < 32; k++) begin
         if (k == abort_k) begin
            rst_n = 1'b0;
            #1;
            chk("abort_valid", int'(chunk_valid), 0);
            chk("abort_busy", int'(busy), 0);
            chk("abort_index", int'(bin_index), 0);
            @(posedge clk);
            #2;
            rst_n = 1'b1;
            step();
            clear_model();
            return;
         end
         chk("drain_valid", int'(chunk_valid), 1);
         chk("drain_busy", int'(busy), 1);
         chk("drain_index", int'(bin_index), 8 * k);
         chk("drain_last", int'(chunk_last), (k == 31) ? 1 : 0);
         for (int j = 0; j < 8; j++) begin
            gv = int'($signed(chunk[j*17 +: 17]));
            chk($sformatf("bin%0d", 8 * k + j), gv, exp_hist[8 * k + j] - fl);
         end
         if (k == stall_k) begin
            cap = chunk;
            chunk_ready = 1'b0;
            for (int s = 0; s < stall_n; s++) begin
               step();
               chk("stall_valid", int'(chunk_valid), 1);
               chk("stall_index", int'(bin_index), 8 * k);
               chk("stall_chunk_held", int'(chunk == cap), 1);
            end
         end
         chunk_ready = 1'b1;
         if (k < drop_n) begin
            pixel_valid = 1'b1;
            pixel       = 8'd9;
            frame_end   = 1'b1;
            frame_start = 1'b1;
         end
         step();
         chunk_ready = 1'b0;
         pixel_valid = 1'b0;
         frame_end   = 1'b0;
         frame_start = 1'b0;
      end
      chk("post_valid", int'(chunk_valid), 0);
      chk("post_busy", int'(busy), 0);
      chk("post_last", int'(chunk_last), 0);
      clear_model();
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      rst_n       = 1'b0;
      frame_start = 1'b0;
      frame_end   = 1'b0;
      pixel_valid = 1'b0;
      pixel       = 8'd0;
      floor_in    = 16'd0;
      chunk_ready = 1'b0;
      clear_model();

      // Reset state
      #12;
      chk("rst_valid", int'(chunk_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_last", int'(chunk_last), 0);
      chk("rst_index", int'(bin_index), 0);
      chk("rst_chunk_zero", int'(chunk == 136'd0), 1);
`ifdef HIST_DROP_CNT_EN
      chk("rst_drop", int'(drop_count), 0);
`endif
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      step();
      chk("idle_busy", int'(busy), 0);

      // Pixels in IDLE (including the start cycle) are ignored
      pixel_valid = 1'b1;
      pixel       = 8'd50;
      step();
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      pixel_valid = 1'b0;
      chk("start_busy", int'(busy), 1);

      // Ten pixels of 200, floor 3; stall five cycles at k=4
      send_pix(200, 10);
      end_frame(1'b0, 0, 3);
      chk("first_drain_valid", int'(chunk_valid), 1);
      drain(3, 4, 5, 0, 99);

      // Saturation: 70000 pixels of 255, floor 0
      start_frame();
      send_pix(255, 70000);
      end_frame(1'b0, 0, 0);
      drain(0, 99, 0, 0, 99);

      // Empty frame: counts were cleared by the previous drain
      start_frame();
      end_frame(1'b0, 0, 0);
      drain(0, 99, 0, 0, 99);

      // Pixel on the frame_end cycle counts; DRAIN pixels and pulses dropped
      start_frame();
      send_pix(40, 2);
      end_frame(1'b1, 9, 1);
      drain(1, 99, 0, 5, 99);
`ifdef HIST_DROP_CNT_EN
      chk("drop_count", int'(drop_count), 5);
`endif

      // Reset mid-drain at k=10 discards the partial histogram
      start_frame();
      send_pix(77, 4);
      end_frame(1'b0, 0, 0);
      drain(0, 99, 0, 0, 10);
      chk("after_abort_busy", int'(busy), 0);
      start_frame();
      send_pix(0, 1);
      end_frame(1'b0, 0, 0);
      drain(0, 99, 0, 0, 99);

      // Back-to-back: start on first IDLE cycle, pixel 1 on the next cycle
      start_frame();
      send_pix(1, 1);
      end_frame(1'b0, 0, 2);
      drain(2, 99, 0, 0, 99);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
